keypad_letter_fsm: RTL and testbench
====================================

Name: keypad_letter_fsm

Overview:
- Downstream consumer of the keypad scanner's `cur_key`/`strobe` outputs.
- Turns key presses into one ASCII letter guess for the Hangman game, using phone-style multi-tap entry.
- Keys 2-9 select and cycle letter groups, '*' clears the candidate, '#' submits it.
- Submitted letters go to the game/transmit logic as a one-cycle `ready` pulse with a stable `letter`.

Parameters:
- TIMEOUT_CYCLES, default 10_000_000, idle cycles after a digit press beyond which a repeat of the same key restarts the group instead of advancing it.

Ports:
- clk  input  1  system clock, rising edge
- nRst  input  1  asynchronous active-low reset
- cur_key  input  8  [7:4] one-hot row, [3:0] one-hot column of pressed key
- strobe  input  1  single-cycle pulse, new key press valid on cur_key
- letter  output  8  ASCII of current candidate; 8'h00 when none
- ready  output  1  one-cycle pulse, letter holds submitted value
- composing  output  1  high while a candidate letter is held

Behaviour:
- Reset (async, nRst=0) values:
  - state=IDLE, letter=8'h00, ready=0, composing=0.
  - timer=0, group=0, idx=0.
- All outputs registered. A strobe sampled at edge N is reflected on the outputs after edge N.
- Key decode: row r = position of the set bit in cur_key[7:4]; column c = position of the set bit in cur_key[3:0]; bit 0 is row/col 0.
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: * 0 # D
- cur_key not exactly one-hot in both nibbles: strobe ignored, no state or timer change.
- Keys 1, 0, A-D: ignored, timer not reset.
- States: IDLE, COMPOSE, SUBMIT.
- IDLE:
  - digit d in 2..9 -> COMPOSE, group=d, idx=0, timer=0.
  - '#' and '*' ignored.
- COMPOSE:
  - digit d == group and timer < TIMEOUT_CYCLES -> idx = (idx+1) mod size(group), timer=0.
  - digit d != group, or timer >= TIMEOUT_CYCLES -> group=d, idx=0, timer=0.
  - '*' -> IDLE, letter=8'h00.
  - '#' -> SUBMIT.
- SUBMIT: lasts exactly one cycle.
  - ready=1, letter=submitted value, composing=0.
  - Any strobe during this cycle is ignored.
  - Next cycle: IDLE, letter=8'h00, ready=0.
- Group sizes: 4 for groups 7 and 9, 3 otherwise.
- Group base offsets: 2:0, 3:3, 4:6, 5:9, 6:12, 7:15, 8:19, 9:22.
- letter = 8'h41 + base(group) + idx whenever in COMPOSE. Maximum value is 'Z' (8'h5A).
- composing = 1 only in COMPOSE.
- Timer:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Increments every cycle in COMPOSE, saturates at TIMEOUT_CYCLES, never wraps.
  - Held at 0 outside COMPOSE.
  - Cleared in the same cycle an accepted digit is processed.
- Simultaneous events: only one key per strobe exists, so no arbitration is needed. A strobe on the cycle the timer reaches TIMEOUT_CYCLES uses the pre-edge timer value for the comparison.
- Reset mid-operation (any state) discards the candidate. No ready pulse is emitted.
- No back-pressure: the consumer must capture letter in the cycle ready=1.

Test Plan:
- Reset, then idle 20 cycles -> letter=8'h00, ready=0, composing=0 throughout; strobe with '#' (8'b1000_0100) -> no ready.
- Press '2' (8'b0001_0010) three times, then '#' -> letter 0x41, 0x42, 0x43 after each strobe; exactly one ready cycle with letter=0x43; following cycle letter=0x00, composing=0.
- Press '7' five times -> P, Q, R, S, P (0x50..0x53, 0x50 wrap); '9' four times then '#' -> ready with 0x5A.
- '2' then '3' -> letter 0x44 ('D', group switch); '*' -> letter 0x00, composing=0; then '#' -> no ready.
- TIMEOUT_CYCLES=8, timeout boundary:
  - '2', wait 10 cycles, '2' -> letter stays 0x41 (restart).
  - Repeat with second press 5 cycles after first -> 0x42.
- Invalid cur_key 8'b0011_0001 with strobe during COMPOSE -> letter, timer progression unchanged.
- Assert nRst mid-COMPOSE (letter=0x45) -> letter=0x00, ready=0 immediately, no pulse after release.

Source files
------------

// File: rtl/keypad_letter_fsm.sv
// rtl/keypad_letter_fsm.sv - multi-tap keypad to ASCII letter entry for Hangman guesses
// Digits 2-9 pick/cycle letter groups, '*' clears, '#' submits via a one-cycle ready pulse.
module keypad_letter_fsm #(
   parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic [7:0] cur_key,
   input  logic       strobe,
   output logic [7:0] letter,
   output logic       ready,
   output logic       composing
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      COMPOSE,
      SUBMIT
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    group_q, group_d;
   logic [1:0]    idx_q, idx_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    letter_q, letter_d;
   logic          ready_q, ready_d;
   logic          composing_q, composing_d;

   logic [1:0] row_idx, col_idx;
   logic       row_ok, col_ok, key_ok;
   logic       is_digit, is_star, is_hash;
   logic [3:0] digit;
   logic       timer_sat;
   logic       digit_hit;

   function automatic logic onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] pos4(input logic [3:0] v);
      case (v)
         4'b0001: return 2'd0;
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic [4:0] group_base(input logic [3:0] g);
      case (g)
         4'd2:    return 5'd0;
         4'd3:    return 5'd3;
         4'd4:    return 5'd6;
         4'd5:    return 5'd9;
         4'd6:    return 5'd12;
         4'd7:    return 5'd15;
         4'd8:    return 5'd19;
         4'd9:    return 5'd22;
         default: return 5'd0;
      endcase
   endfunction

   function automatic logic [1:0] group_last(input logic [3:0] g);
      return (g == 4'd7 || g == 4'd9) ? 2'd3 : 2'd2;
   endfunction

   always_comb begin
      row_ok   = onehot4(cur_key[7:4]);
      col_ok   = onehot4(cur_key[3:0]);
      row_idx  = pos4(cur_key[7:4]);
      col_idx  = pos4(cur_key[3:0]);
      key_ok   = strobe && row_ok && col_ok;
      // Digit keys 1-9 occupy the top-left 3x3 block; key 1 is excluded
      is_digit = key_ok && (row_idx != 2'd3) && (col_idx != 2'd3)
                 && !((row_idx == 2'd0) && (col_idx == 2'd0));
      digit    = ({2'b00, row_idx} * 4'd3) + {2'b00, col_idx} + 4'd1;
      is_star  = key_ok && (row_idx == 2'd3) && (col_idx == 2'd0);
      is_hash  = key_ok && (row_idx == 2'd3) && (col_idx == 2'd2);
   end

   assign timer_sat = (timer_q >= TW'(TIMEOUT_CYCLES));

   always_comb begin
      state_d   = state_q;
      group_d   = group_q;
      idx_d     = idx_q;
      digit_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_digit) begin
               state_d   = COMPOSE;
               group_d   = digit;
               idx_d     = 2'd0;
               digit_hit = 1'b1;
            end
         end
         COMPOSE: begin
            if (is_digit) begin
               digit_hit = 1'b1;
               if ((digit == group_q) && !timer_sat) begin
                  idx_d = (idx_q == group_last(group_q)) ? 2'd0 : idx_q + 2'd1;
               end else begin
                  group_d = digit;
                  idx_d   = 2'd0;
               end
            end else if (is_star) begin
               state_d = IDLE;
            end else if (is_hash) begin
               state_d = SUBMIT;
            end
         end
         SUBMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (state_d == IDLE) begin
         group_d = 4'd0;
         idx_d   = 2'd0;
      end

      if ((state_d != COMPOSE) || digit_hit) begin
         timer_d = '0;
      end else if (!timer_sat) begin
         timer_d = timer_q + TW'(1);
      end else begin
         timer_d = timer_q;
      end

      // SUBMIT reuses the letter already held from COMPOSE
      case (state_d)
         COMPOSE: letter_d = 8'h41 + {3'b000, group_base(group_d)} + {6'b000000, idx_d};
         SUBMIT:  letter_d = letter_q;
         default: letter_d = 8'h00;
      endcase
      ready_d     = (state_d == SUBMIT);
      composing_d = (state_d == COMPOSE);
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q     <= IDLE;
         group_q     <= 4'd0;
         idx_q       <= 2'd0;
         timer_q     <= '0;
         letter_q    <= 8'h00;
         ready_q     <= 1'b0;
         composing_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         group_q     <= group_d;
         idx_q       <= idx_d;
         timer_q     <= timer_d;
         letter_q    <= letter_d;
         ready_q     <= ready_d;
         composing_q <= composing_d;
      end
   end

   assign letter    = letter_q;
   assign ready     = ready_q;
   assign composing = composing_q;

endmodule

// File: tb/tb_keypad_letter_fsm.sv
// tb/tb_keypad_letter_fsm.sv - scoreboard bench for keypad_letter_fsm
module tb_keypad_letter_fsm;

   localparam logic [7:0] K1    = 8'b0001_0001;
   localparam logic [7:0] K2    = 8'b0001_0010;
   localparam logic [7:0] K3    = 8'b0001_0100;
   localparam logic [7:0] K5    = 8'b0010_0010;
   localparam logic [7:0] K7    = 8'b0100_0001;
   localparam logic [7:0] K9    = 8'b0100_0100;
   localparam logic [7:0] KSTAR = 8'b1000_0001;
   localparam logic [7:0] KHASH = 8'b1000_0100;
   localparam logic [7:0] KBAD  = 8'b0011_0001;

   logic       clk = 1'b0;
   logic       nRst = 1'b0;
   logic [7:0] cur_key = 8'h00;
   logic       strobe = 1'b0;
   logic [7:0] letter;
   logic       ready;
   logic       composing;

   int n_checks = 0;
   int n_fail   = 0;
   int ready_cnt = 0;

   logic [7:0] exp_q[$];
   logic       comp_q[$];

   keypad_letter_fsm #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk),
      .nRst(nRst),
      .cur_key(cur_key),
      .strobe(strobe),
      .letter(letter),
      .ready(ready),
      .composing(composing)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ready === 1'b1) ready_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic press(input logic [7:0] key, input logic [7:0] exp, input logic comp);
      exp_q.push_back(exp);
      comp_q.push_back(comp);
      @(negedge clk);
      cur_key = key;
      strobe  = 1'b1;
      @(posedge clk);
      #1;
      strobe  = 1'b0;
      cur_key = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic score(input string name);
      logic [7:0] e;
      logic       c;
      e = exp_q.pop_front();
      c = comp_q.pop_front();
      n_checks++;
      if (letter !== e || composing !== c) begin
         n_fail++;
         $display("FAIL %s: letter=%h composing=%b, expected letter=%h composing=%b",
                  name, letter, composing, e, c);
      end
   endtask

   task automatic test_reset();
      int rc;
      nRst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (letter !== 8'h00 || ready !== 1'b0 || composing !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: letter=%h ready=%b composing=%b, expected 00/0/0",
                  letter, ready, composing);
      end
      @(negedge clk);
      nRst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (letter !== 8'h00 || ready !== 1'b0 || composing !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_cycle_%0d: letter=%h ready=%b composing=%b, expected 00/0/0",
                     i, letter, ready, composing);
         end
      end
      rc = ready_cnt;
      press(KHASH, 8'h00, 1'b0);
      score("idle_hash");
      idle(2);
      n_checks++;
      if (ready_cnt !== rc) begin
         n_fail++;
         $display("FAIL idle_hash_ready: ready pulses=%0d, expected %0d", ready_cnt, rc);
      end
   endtask

   task automatic check_submit(input string name, input logic [7:0] exp);
      int rc;
      rc = ready_cnt;
      press(KHASH, exp, 1'b0);
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready: ready=%b, expected 1", name, ready);
      end
      score(name);
      idle(1);
      n_checks++;
      if (ready !== 1'b0 || letter !== 8'h00 || composing !== 1'b0 || ready_cnt !== rc + 1) begin
         n_fail++;
         $display("FAIL %s_after: ready=%b letter=%h composing=%b pulses=%0d, expected 0/00/0/%0d",
                  name, ready, letter, composing, ready_cnt - rc, 1);
      end
   endtask

   task automatic test_multitap();
      logic [7:0] exps[3] = '{8'h41, 8'h42, 8'h43};
      foreach (exps[i]) begin
         press(K2, exps[i], 1'b1);
         score("tap_2");
      end
      check_submit("submit_C", 8'h43);
   endtask

   task automatic test_wrap();
      logic [7:0] e7[5] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h50};
      logic [7:0] e9[4] = '{8'h57, 8'h58, 8'h59, 8'h5A};
      foreach (e7[i]) begin
         press(K7, e7[i], 1'b1);
         score("tap_7");
      end
      foreach (e9[i]) begin
         press(K9, e9[i], 1'b1);
         score("tap_9");
      end
      check_submit("submit_Z", 8'h5A);
   endtask

   task automatic test_switch_clear();
      int rc;
      press(K2, 8'h41, 1'b1);
      score("switch_first");
      press(K3, 8'h44, 1'b1);
      score("switch_group");
      press(KSTAR, 8'h00, 1'b0);
      score("star_clear");
      rc = ready_cnt;
      press(KHASH, 8'h00, 1'b0);
      score("hash_after_clear");
      idle(2);
      n_checks++;
      if (ready_cnt !== rc) begin
         n_fail++;
         $display("FAIL hash_after_clear_ready: pulses=%0d, expected %0d", ready_cnt - rc, 0);
      end
   endtask

   task automatic test_timeout();
      // gap cycles between presses, and whether the second press should advance
      int   gaps[4] = '{10, 3, 7, 8};
      logic [7:0] second[4] = '{8'h41, 8'h42, 8'h42, 8'h41};
      foreach (gaps[i]) begin
         press(KSTAR, 8'h00, 1'b0);
         press(K2, 8'h41, 1'b1);
         score("timeout_first");
         idle(gaps[i]);
         press(K2, second[i], 1'b1);
         score($sformatf("timeout_gap%0d", gaps[i]));
      end
      press(KSTAR, 8'h00, 1'b0);
      score("timeout_clear");
      // the clears pushed earlier were not scored inline; drain them in order
   endtask

   task automatic test_invalid_key();
      press(KSTAR, 8'h00, 1'b0);
      score("inv_clear");
      press(K2, 8'h41, 1'b1);
      score("inv_first");
      idle(7);
      press(KBAD, 8'h41, 1'b1);
      score("inv_bad_key");
      press(K2, 8'h41, 1'b1);
      score("inv_timer_kept");
      press(K1, 8'h41, 1'b1);
      score("inv_key1");
      press(K2, 8'h42, 1'b1);
      score("inv_key1_advance");
      press(KSTAR, 8'h00, 1'b0);
      score("inv_end");
   endtask

   task automatic test_back_to_back();
      press(K2, 8'h41, 1'b1);
      score("b2b_first");
      press(KHASH, 8'h41, 1'b0);
      score("b2b_submit");
      press(K5, 8'h00, 1'b0);
      score("b2b_ignored_in_submit");
      press(K5, 8'h4A, 1'b1);
      score("b2b_next");
      press(KSTAR, 8'h00, 1'b0);
      score("b2b_clear");
   endtask

   task automatic test_reset_mid();
      int rc;
      press(K2, 8'h41, 1'b1);
      score("rst_a");
      press(K3, 8'h44, 1'b1);
      score("rst_b");
      press(K3, 8'h45, 1'b1);
      score("rst_c");
      rc = ready_cnt;
      #2;
      nRst = 1'b0;
      #1;
      n_checks++;
      if (letter !== 8'h00 || ready !== 1'b0 || composing !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: letter=%h ready=%b composing=%b, expected 00/0/0",
                  letter, ready, composing);
      end
      @(negedge clk);
      nRst = 1'b1;
      idle(5);
      n_checks++;
      if (ready_cnt !== rc || letter !== 8'h00 || composing !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: pulses=%0d letter=%h composing=%b, expected 0/00/0",
                  ready_cnt - rc, letter, composing);
      end
   endtask

   task automatic drain_timeout_clears();
      // test_timeout issues unscored clears; drop their entries before the next test
      while (exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         void'(comp_q.pop_front());
      end
   endtask

   initial begin
      test_reset();
      test_multitap();
      test_wrap();
      test_switch_clear();
      test_back_to_back();
      test_invalid_key();
      test_timeout_scored();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   task automatic test_timeout_scored();
      int   gaps[4] = '{10, 3, 7, 8};
      logic [7:0] second[4] = '{8'h41, 8'h42, 8'h42, 8'h41};
      foreach (gaps[i]) begin
         press(KSTAR, 8'h00, 1'b0);
         score("timeout_clear");
         press(K2, 8'h41, 1'b1);
         score("timeout_first");
         idle(gaps[i]);
         press(K2, second[i], 1'b1);
         score($sformatf("timeout_gap%0d", gaps[i]));
      end
      press(KSTAR, 8'h00, 1'b0);
      score("timeout_end");
      drain_timeout_clears();
   endtask

endmodule
